pwm_gen: RTL and testbench



---
 rtl/pwm_gen_if.sv | 20 ++
 rtl/pwm_gen.sv | 125 ++++++++++++
 tb/tb_pwm_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pwm_gen_if.sv
// Duty/enable input bus and gate-drive outputs of the PWM generator.
// master = the control side that supplies duty and enable, slave = pwm_gen.
interface pwm_gen_if;
  logic [13:0] duty;
  logic        duty_vld;
  logic        pwm_en;
  logic        pwm_hi;
  logic        pwm_lo;
  logic        cycle_start;

  modport master (
    output duty, duty_vld, pwm_en,
    input  pwm_hi, pwm_lo, cycle_start
  );

  modport slave (
    input  duty, duty_vld, pwm_en,
    output pwm_hi, pwm_lo, cycle_start
  );
endinterface

// File: rtl/pwm_gen.sv
// Complementary PWM pair with dead-time insertion and a double-buffered duty.
// The period is fixed at 8192 clocks, and duty updates apply at period boundaries.
module pwm_gen #(
  parameter int unsigned DEAD = 8  // dead time in clocks, 1..255
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_gen_if.slave   bus
);

  localparam logic [7:0] DEAD_M1 = 8'(DEAD - 1);

  typedef enum logic [2:0] {IDLE, LO_ON, DT_RISE, HI_ON, DT_FALL} state_t;

  state_t      state_reg;
  logic [12:0] cnt_reg;
  logic [12:0] shadow_reg;
  logic [12:0] act_reg;
  logic        pend_reg;
  logic [7:0]  dcnt_reg;
  logic        hi_reg;
  logic        lo_reg;
  logic        cs_reg;

  logic        en;
  logic        raw;
  logic [12:0] duty_clamped;

  assign en           = bus.pwm_en;
  assign raw          = en && (cnt_reg < act_reg);
  assign duty_clamped = bus.duty[13] ? 13'd0 : bus.duty[12:0];

  // Counter, duty double buffer and period strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      shadow_reg <= '0;
      act_reg    <= '0;
      pend_reg   <= 1'b0;
      cs_reg     <= 1'b0;
    end else begin
      cnt_reg <= en ? cnt_reg + 13'd1 : 13'd0;
      // Registered strobe: appears in the cycle after the enabled cnt==0 cycle
      cs_reg  <= en && (cnt_reg == 13'd0);

      if (!en) begin
        act_reg  <= shadow_reg;
        pend_reg <= 1'b0;
      end else if ((cnt_reg == 13'h1FFF) && pend_reg) begin
        act_reg  <= shadow_reg;
        pend_reg <= 1'b0;
      end

      // A new strobe wins over the transfer: it stays pending for the next boundary
      if (bus.duty_vld) begin
        shadow_reg <= duty_clamped;
        pend_reg   <= 1'b1;
      end
    end
  end

  // Dead-time FSM; hi_reg/lo_reg track the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      dcnt_reg  <= '0;
      hi_reg    <= 1'b0;
      lo_reg    <= 1'b0;
    end else if (!en) begin
      state_reg <= IDLE;
      hi_reg    <= 1'b0;
      lo_reg    <= 1'b0;
    end else begin
      hi_reg <= 1'b0;
      lo_reg <= 1'b0;
      case (state_reg)
        IDLE, LO_ON: begin
          if (raw) begin
            state_reg <= DT_RISE;
            dcnt_reg  <= DEAD_M1;
          end else begin
            state_reg <= LO_ON;
            lo_reg    <= 1'b1;
          end
        end
        DT_RISE: begin
          if (!raw) begin
            state_reg <= LO_ON;
            lo_reg    <= 1'b1;
          end else if (dcnt_reg == 8'd0) begin
            state_reg <= HI_ON;
            hi_reg    <= 1'b1;
          end else begin
            dcnt_reg  <= dcnt_reg - 8'd1;
          end
        end
        HI_ON: begin
          if (!raw) begin
            state_reg <= DT_FALL;
            dcnt_reg  <= DEAD_M1;
          end else begin
            hi_reg    <= 1'b1;
          end
        end
        DT_FALL: begin
          if (raw) begin
            state_reg <= HI_ON;
            hi_reg    <= 1'b1;
          end else if (dcnt_reg == 8'd0) begin
            state_reg <= LO_ON;
            lo_reg    <= 1'b1;
          end else begin
            dcnt_reg  <= dcnt_reg - 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.pwm_hi      = hi_reg;
  assign bus.pwm_lo      = lo_reg;
  assign bus.cycle_start = cs_reg;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed bench for pwm_gen: measures whole 8192-clock periods and compares
// pulse widths, strobe timing and enable/reset behaviour with hand-derived values.
module tb_pwm_gen;

  localparam int DEAD = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run = 0;
  int   tests_failed = 0;

  pwm_gen_if bus ();

  pwm_gen #(.DEAD(DEAD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Waits for cycle_start, then samples one 8192-cycle window starting there.
  // Window index i sees cnt == (i+1) mod 8192; an optional strobe is issued at index strobe_idx.
  task automatic run_period(input int strobe_idx, input logic [13:0] strobe_val,
                            output int waited, output int hi_n, output int lo_n,
                            output int ovl, output int hi_rise, output int lo_rise,
                            output int first_hi, output int cs_n);
    logic prev_hi, prev_lo;
    waited = 0;
    for (int w = 0; w < 9000; w++) begin
      @(negedge clk);
      waited++;
      if (bus.cycle_start) break;
    end
    hi_n = 0; lo_n = 0; ovl = 0; hi_rise = 0; lo_rise = 0; first_hi = -1; cs_n = 0;
    prev_hi = bus.pwm_hi;
    prev_lo = bus.pwm_lo;
    for (int i = 0; i < 8192; i++) begin
      if (i > 0) @(negedge clk);
      hi_n += int'(bus.pwm_hi);
      lo_n += int'(bus.pwm_lo);
      cs_n += int'(bus.cycle_start);
      if (bus.pwm_hi && bus.pwm_lo) ovl++;
      if (bus.pwm_hi && !prev_hi) hi_rise++;
      if (bus.pwm_lo && !prev_lo) lo_rise++;
      if (bus.pwm_hi && first_hi < 0) first_hi = i;
      prev_hi = bus.pwm_hi;
      prev_lo = bus.pwm_lo;
      if (bus.duty_vld) bus.duty_vld = 1'b0;
      if (i == strobe_idx) begin
        bus.duty     = strobe_val;
        bus.duty_vld = 1'b1;
      end
    end
    bus.duty_vld = 1'b0;
    $display("[TB] period: wait=%0d hi=%0d lo=%0d ovl=%0d hi_rise=%0d lo_rise=%0d first_hi=%0d cs=%0d",
             waited, hi_n, lo_n, ovl, hi_rise, lo_rise, first_hi, cs_n);
  endtask

  task automatic test_reset();
    int hi_seen;
    rst_n = 1'b0; bus.pwm_en = 1'b1; bus.duty_vld = 1'b1; bus.duty = 14'h1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if ({bus.pwm_hi, bus.pwm_lo, bus.cycle_start} !== 3'b000) begin tests_failed++; $display("FAIL reset_hold[%0d]: got hi/lo/cs=%b expected 000", i, {bus.pwm_hi, bus.pwm_lo, bus.cycle_start}); end
    end
    rst_n = 1'b1; bus.pwm_en = 1'b0; bus.duty_vld = 1'b0;
    @(negedge clk);
    bus.pwm_en = 1'b1;
    @(negedge clk);
    $display("[TB] reset released, first enabled cycle: cs=%b lo=%b hi=%b", bus.cycle_start, bus.pwm_lo, bus.pwm_hi);
    tests_run++; if (bus.cycle_start !== 1'b1) begin tests_failed++; $display("FAIL reset_first_cs: got %b expected 1", bus.cycle_start); end
    tests_run++; if (bus.pwm_lo !== 1'b1) begin tests_failed++; $display("FAIL reset_zero_duty_lo: got %b expected 1", bus.pwm_lo); end
    hi_seen = 0;
    repeat (30) begin
      @(negedge clk);
      hi_seen += int'(bus.pwm_hi);
    end
    tests_run++; if (hi_seen !== 0) begin tests_failed++; $display("FAIL reset_shadow_cleared: got %0d hi cycles expected 0", hi_seen); end
    bus.pwm_en = 1'b0;
    @(negedge clk);
    bus.duty = 14'h1000; bus.duty_vld = 1'b1;
    @(negedge clk);
    bus.duty_vld = 1'b0;
    @(negedge clk);
    bus.pwm_en = 1'b1;
    repeat (20) @(negedge clk);
    tests_run++; if (bus.pwm_hi !== 1'b1) begin tests_failed++; $display("FAIL reset_pre_hi_on: got %b expected 1", bus.pwm_hi); end
    rst_n = 1'b0;
    @(negedge clk);
    $display("[TB] reset mid HI_ON: hi=%b lo=%b cs=%b", bus.pwm_hi, bus.pwm_lo, bus.cycle_start);
    tests_run++; if ({bus.pwm_hi, bus.pwm_lo, bus.cycle_start} !== 3'b000) begin tests_failed++; $display("FAIL reset_mid_pulse: got hi/lo/cs=%b expected 000", {bus.pwm_hi, bus.pwm_lo, bus.cycle_start}); end
    rst_n = 1'b1; bus.pwm_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_duty_50();
    int wt, hn, ln, ov, hr, lr, fh, cs;
    @(negedge clk);
    bus.duty = 14'h1000; bus.duty_vld = 1'b1;
    @(negedge clk);
    bus.duty_vld = 1'b0;
    @(negedge clk);
    bus.pwm_en = 1'b1;
    // Period A: 50 %, with 0x0800 strobed at cnt=100 (must not affect this period)
    run_period(99, 14'h0800, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (wt !== 1) begin tests_failed++; $display("FAIL A.cs_latency: got %0d expected 1", wt); end
    tests_run++; if (fh !== DEAD) begin tests_failed++; $display("FAIL A.first_hi: got %0d expected %0d", fh, DEAD); end
    tests_run++; if (hn !== 4088) begin tests_failed++; $display("FAIL A.hi: got %0d expected 4088", hn); end
    tests_run++; if (ln !== 4088) begin tests_failed++; $display("FAIL A.lo: got %0d expected 4088", ln); end
    tests_run++; if (ov !== 0) begin tests_failed++; $display("FAIL A.overlap: got %0d expected 0", ov); end
    tests_run++; if (cs !== 1) begin tests_failed++; $display("FAIL A.cs_count: got %0d expected 1", cs); end
    tests_run++; if (hr !== 1) begin tests_failed++; $display("FAIL A.hi_rises: got %0d expected 1", hr); end
  endtask

  task automatic test_double_buffer();
    int wt, hn, ln, ov, hr, lr, fh, cs;
    // Period B: 0x0800 now active; 0x1000 strobed at cnt=8191
    run_period(8190, 14'h1000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (wt !== 1) begin tests_failed++; $display("FAIL B.period: got %0d expected 1", wt); end
    tests_run++; if (hn !== 2040) begin tests_failed++; $display("FAIL B.hi: got %0d expected 2040", hn); end
    tests_run++; if (ln !== 6136) begin tests_failed++; $display("FAIL B.lo: got %0d expected 6136", ln); end
    tests_run++; if (ov !== 0) begin tests_failed++; $display("FAIL B.overlap: got %0d expected 0", ov); end
    // Period C: the cnt=8191 strobe is delayed one more period
    run_period(-1, 14'h0000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 2040) begin tests_failed++; $display("FAIL C.hi: got %0d expected 2040", hn); end
    tests_run++; if (ln !== 6136) begin tests_failed++; $display("FAIL C.lo: got %0d expected 6136", ln); end
    // Period D: 0x1000 applies; 0x1FFF strobed for the clamp test
    run_period(50, 14'h1FFF, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 4088) begin tests_failed++; $display("FAIL D.hi: got %0d expected 4088", hn); end
    tests_run++; if (ln !== 4088) begin tests_failed++; $display("FAIL D.lo: got %0d expected 4088", ln); end
  endtask

  task automatic test_clamps();
    int wt, hn, ln, ov, hr, lr, fh, cs;
    // Period E: first 0x1FFF period, hi after the initial dead time
    run_period(-1, 14'h0000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 8183) begin tests_failed++; $display("FAIL E.hi: got %0d expected 8183", hn); end
    tests_run++; if (ln !== 0) begin tests_failed++; $display("FAIL E.lo: got %0d expected 0", ln); end
    // Period E2: steady max duty, low pulse swallowed; 0x2000 strobed
    run_period(50, 14'h2000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 8191) begin tests_failed++; $display("FAIL E2.hi: got %0d expected 8191", hn); end
    tests_run++; if (ln !== 0) begin tests_failed++; $display("FAIL E2.lo: got %0d expected 0", ln); end
    // Period F: negative duty clamps to 0 %; 0x0005 strobed
    run_period(50, 14'h0005, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 0) begin tests_failed++; $display("FAIL F.hi: got %0d expected 0", hn); end
    tests_run++; if (ln !== 8185) begin tests_failed++; $display("FAIL F.lo: got %0d expected 8185", ln); end
  endtask

  task automatic test_short_pulse();
    int wt, hn, ln, ov, hr, lr, fh, cs;
    // Period G: 5-cycle raw pulse is swallowed; 0x1000 strobed for the enable test
    run_period(50, 14'h1000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (hn !== 0) begin tests_failed++; $display("FAIL G.hi: got %0d expected 0", hn); end
    tests_run++; if (ln !== 8187) begin tests_failed++; $display("FAIL G.lo: got %0d expected 8187", ln); end
    tests_run++; if (lr !== 1) begin tests_failed++; $display("FAIL G.lo_rises: got %0d expected 1", lr); end
  endtask

  task automatic test_enable();
    int wt, hn, ln, ov, hr, lr, fh, cs;
    int waited;
    waited = 0;
    for (int w = 0; w < 9000; w++) begin
      @(negedge clk);
      waited++;
      if (bus.cycle_start) break;
    end
    tests_run++; if (waited !== 1) begin tests_failed++; $display("FAIL H.period: got %0d expected 1", waited); end
    repeat (100) @(negedge clk);
    tests_run++; if (bus.pwm_hi !== 1'b1) begin tests_failed++; $display("FAIL H.hi_on: got %b expected 1", bus.pwm_hi); end
    bus.pwm_en = 1'b0;
    @(negedge clk);
    $display("[TB] enable dropped: hi=%b lo=%b cs=%b", bus.pwm_hi, bus.pwm_lo, bus.cycle_start);
    tests_run++; if ({bus.pwm_hi, bus.pwm_lo, bus.cycle_start} !== 3'b000) begin tests_failed++; $display("FAIL H.disable: got hi/lo/cs=%b expected 000", {bus.pwm_hi, bus.pwm_lo, bus.cycle_start}); end
    bus.duty = 14'h0800; bus.duty_vld = 1'b1;
    @(negedge clk);
    bus.duty_vld = 1'b0;
    @(negedge clk);
    bus.pwm_en = 1'b1;
    // Period H2: latest duty 0x0800 used right after re-enable
    run_period(-1, 14'h0000, wt, hn, ln, ov, hr, lr, fh, cs);
    tests_run++; if (wt !== 1) begin tests_failed++; $display("FAIL H2.cs_latency: got %0d expected 1", wt); end
    tests_run++; if (fh !== DEAD) begin tests_failed++; $display("FAIL H2.first_hi: got %0d expected %0d", fh, DEAD); end
    tests_run++; if (hn !== 2040) begin tests_failed++; $display("FAIL H2.hi: got %0d expected 2040", hn); end
    tests_run++; if (ln !== 6136) begin tests_failed++; $display("FAIL H2.lo: got %0d expected 6136", ln); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.duty = '0; bus.duty_vld = 1'b0; bus.pwm_en = 1'b0; rst_n = 1'b0;
    test_reset();
    test_duty_50();
    test_double_buffer();
    test_clamps();
    test_short_pulse();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
